// File: rtl/aes_pkg.sv
// Shared AES types, sizes and GF(2^8) helpers for the encrypt core.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS  = 14;
    localparam int unsigned NUM_KEYS    = NUM_ROUNDS + 1;
    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned ROUND_W     = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned COL_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (skipped on the last round) and AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_in,
    input  logic [AES_BLOCK_W-1:0] round_key,
    input  logic                   last_round,
    output logic [AES_BLOCK_W-1:0] state_out
);

    // Column-major byte arrays indexed [column][row].
    logic [3:0][COL_W-1:0] sub_col;
    logic [BYTE_W-1:0]     sub_b [4][4];
    logic [BYTE_W-1:0]     sr_b  [4][4];
    logic [BYTE_W-1:0]     mc_b  [4][4];

    for (genvar c = 0; c < 4; c++) begin : g_col
        // SubBytes one column at a time through the shared S-box.
        aes_subword u_subword (
            .word   (state_in[AES_BLOCK_W-1-COL_W*c -: COL_W]),
            .result (sub_col[c])
        );

        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sub_b[c][r] = sub_col[c][COL_W-1-BYTE_W*r -: BYTE_W];
            // Row r rotates left by r columns.
            assign sr_b[c][r]  = sub_b[(c + r) % 4][r];
            assign state_out[AES_BLOCK_W-1-COL_W*c-BYTE_W*r -: BYTE_W] =
                (last_round ? sr_b[c][r] : mc_b[c][r])
                ^ round_key[AES_BLOCK_W-1-COL_W*c-BYTE_W*r -: BYTE_W];
        end

        // MixColumns: fixed matrix {02 03 01 01} rotated per row.
        assign mc_b[c][0] = xtime(sr_b[c][0]) ^ xtime(sr_b[c][1]) ^ sr_b[c][1]
                            ^ sr_b[c][2] ^ sr_b[c][3];
        assign mc_b[c][1] = sr_b[c][0] ^ xtime(sr_b[c][1]) ^ xtime(sr_b[c][2])
                            ^ sr_b[c][2] ^ sr_b[c][3];
        assign mc_b[c][2] = sr_b[c][0] ^ sr_b[c][1] ^ xtime(sr_b[c][2])
                            ^ xtime(sr_b[c][3]) ^ sr_b[c][3];
        assign mc_b[c][3] = xtime(sr_b[c][0]) ^ sr_b[c][0] ^ sr_b[c][1]
                            ^ sr_b[c][2] ^ xtime(sr_b[c][3]);
    end

endmodule

// File: rtl/aes_subword.sv
// SubWord: forward AES S-box applied to each byte of a 32-bit word.
module aes_subword (
    input  logic [31:0] word,
    output logic [31:0] result
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = {SBOX[word[31:24]], SBOX[word[23:16]],
                     SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-256 encryption core: one round per cycle, valid/ready
// handshakes on both sides, round keys supplied by an external schedule.
module aes_encrypt_core
    import aes_pkg::AES_BLOCK_W, aes_pkg::NUM_KEYS, aes_pkg::ROUND_W;
#(
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  key_valid,
    input  logic [NUM_KEYS-1:0][AES_BLOCK_W-1:0]  round_key,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [AES_BLOCK_W-1:0]                plaintext,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [AES_BLOCK_W-1:0]                ciphertext
);

    aes_pkg::aes_state_e state_q;
    aes_pkg::aes_state_e state_d;

    logic [ROUND_W-1:0]     round_q;
    logic [AES_BLOCK_W-1:0] data_q;
    logic [AES_BLOCK_W-1:0] rk_sel;
    logic [AES_BLOCK_W-1:0] round_out;
    logic                   last_round;
    logic                   accept;
    logic                   advance;

    assign last_round = (round_q == ROUND_W'(NUM_ROUNDS));
    assign accept     = (state_q == aes_pkg::IDLE) && in_valid && in_ready;
    assign advance    = (state_q == aes_pkg::BUSY) && key_valid;
    assign ciphertext = data_q;

    // Round key is read live from the schedule; index 15 never feeds a round.
    assign rk_sel = (round_q < ROUND_W'(NUM_KEYS)) ? round_key[round_q] : '0;

    aes_round u_round (
        .state_in   (data_q),
        .round_key  (rk_sel),
        .last_round (last_round),
        .state_out  (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= aes_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a dropped key aborts an in-flight block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            aes_pkg::IDLE: begin
                if (accept) begin
                    state_d = aes_pkg::BUSY;
                end
            end
            aes_pkg::BUSY: begin
                if (!key_valid) begin
                    state_d = aes_pkg::IDLE;
                end else if (last_round) begin
                    state_d = aes_pkg::DONE;
                end
            end
            aes_pkg::DONE: begin
                if (out_ready) begin
                    state_d = aes_pkg::IDLE;
                end
            end
            default: begin
                state_d = aes_pkg::IDLE;
            end
        endcase
    end

    // FSM outputs: ready only in IDLE with a key, valid only in DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            aes_pkg::IDLE: in_ready  = key_valid && !rst;
            aes_pkg::DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: initial AddRoundKey on accept, one full round per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            data_q  <= '0;
        end else if (accept) begin
            data_q  <= plaintext ^ round_key[0];
            round_q <= ROUND_W'(1);
        end else if (advance) begin
            data_q  <= round_out;
            round_q <= round_q + ROUND_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core using published AES-256 vectors.
module tb_aes_encrypt_core;

    logic                clk;
    logic                rst;
    logic                key_valid;
    logic [14:0][127:0]  round_key;
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        plaintext;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        ciphertext;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] PT_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_SP2 = 128'h591ccb10d410ed26dc5ba74a31362870;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acc_cyc    = 0;
    int acc_count  = 0;
    int rise_count = 0;
    int done_count = 0;
    int acc_q[$];
    logic [127:0] sb[$];
    logic prev_ov = 1'b0;
    logic [7:0] sbox_m [256];

    aes_encrypt_core #(.NUM_ROUNDS(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .round_key  (round_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box derived from the field inverse and affine map, not a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, output logic [14:0][127:0] rk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word_m(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [255:0] key);
        logic [14:0][127:0] rk;
        key_valid = 1'b0;
        expand_key(key, rk);
        round_key = rk;
        @(posedge clk); #1;
        key_valid = 1'b1;
    endtask

    // Offer one block, push its expected result, return one cycle after accept.
    task automatic send_block(input logic [127:0] pt, input logic [127:0] ct);
        int n;
        n = 0;
        sb.push_back(ct);
        plaintext = pt;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_seen", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_count", 128'(done_count), 128'(target));
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 128'(out_valid), 128'd1);
    endtask

    // Monitor: accept times, latency, and scoreboard pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                rise_count++;
                check("latency", 128'(cyc - acc_cyc), 128'd15);
            end
            if (out_valid && out_ready) begin
                done_count++;
                check("sb_nonempty", 128'(sb.size() > 0), 128'd1);
                if (sb.size() > 0) check("ciphertext", ciphertext, sb.pop_front());
            end
            if (in_valid && in_ready) begin
                acc_count++;
                acc_cyc = cyc;
                acc_q.push_back(cyc);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_rise, base_done, interval;
        rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; round_key = '0;
        build_sbox();

        // Reset dominates a valid key and offered plaintext.
        load_key(KEY_C3);
        plaintext = PT_C3;
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_state",     ciphertext,      128'd0);

        // No key: offered plaintext is never taken.
        @(posedge clk); #1;
        rst = 1'b0; key_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gate_in_ready",  128'(in_ready),  128'd0);
            check("gate_out_valid", 128'(out_valid), 128'd0);
        end
        check("gate_no_accept", 128'(acc_count), 128'd0);

        // FIPS-197 C.3 single block.
        @(posedge clk); #1;
        in_valid = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
        send_block(PT_C3, CT_C3);
        wait_done(1);

        // Backpressure: result held for 20+ cycles, plaintext ignored meanwhile.
        load_key(KEY_SP);
        out_ready = 1'b0;
        send_block(PT_SP1, CT_SP1);
        base_acc  = acc_count;
        plaintext = PT_SP2;
        in_valid  = 1'b1;
        wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid",  128'(out_valid), 128'd1);
            check("bp_ciphertext", ciphertext,      CT_SP1);
            check("bp_in_ready",   128'(in_ready),  128'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_out_valid", 128'(out_valid), 128'd0);
        check("bp_idle_in_ready",  128'(in_ready),  128'd1);
        check("bp_no_accept",      128'(acc_count), 128'(base_acc));

        // Back-to-back blocks with continuous valid/ready.
        @(posedge clk); #1;
        out_ready = 1'b1;
        base_done = done_count;
        send_block(PT_SP1, CT_SP1);
        send_block(PT_SP2, CT_SP2);
        interval = acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2];
        check("b2b_interval", 128'(interval), 128'd16);
        wait_done(base_done + 2);

        // Reset seven cycles after accept discards the block.
        load_key(KEY_C3);
        send_block(PT_C3, CT_C3);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_in_ready",  128'(in_ready),  128'd1);
        check("mid_rst_state",     ciphertext,      128'd0);
        base_rise = rise_count;
        base_done = done_count;
        @(posedge clk); #1;
        send_block(PT_C3, CT_C3);
        wait_done(base_done + 1);
        check("mid_rst_rerun_rise", 128'(rise_count), 128'(base_rise + 1));

        // Key dropped five cycles after accept aborts the block.
        send_block(PT_C3, CT_C3);
        repeat (4) @(posedge clk);
        #1;
        key_valid = 1'b0;
        in_valid  = 1'b1;
        sb.delete();
        base_rise = rise_count;
        base_acc  = acc_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("drop_out_valid", 128'(out_valid), 128'd0);
            check("drop_in_ready",  128'(in_ready),  128'd0);
        end
        check("drop_no_accept", 128'(acc_count),  128'(base_acc));
        check("drop_no_output", 128'(rise_count), 128'(base_rise));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        key_valid = 1'b1;
        base_done = done_count;
        send_block(PT_C3, CT_C3);
        wait_done(base_done + 1);

        repeat (3) @(posedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 14, meaning AES-256 round count; no other value is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port key_valid  input  1  high when round_key holds a complete, stable expanded key schedule.
REQ-005 SHALL have port round_key  input  128 x 15 (index 14:0)  expanded AES-256 round keys; index 0 = cipher key bits [255:128], index 1 = cipher key bits [127:0].
REQ-006 SHALL have port in_valid  input  1  plaintext offered.
REQ-007 SHALL have port in_ready  output  1  core can accept plaintext.
REQ-008 SHALL have port plaintext  input  128  block; bit [127:120] = FIPS-197 byte 0, column-major.
REQ-009 SHALL have port out_valid  output  1  ciphertext available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-011 SHALL have port ciphertext  output  128  result, same byte order as plaintext.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE, in_ready SHALL equal key_valid; in BUSY and DONE, in_ready SHALL be 0.
REQ-014 Accept (IDLE, in_valid && in_ready) SHALL load state <= plaintext ^ round_key[0], round counter <= 1, go to BUSY.
REQ-015 In BUSY, each cycle SHALL apply SubBytes, ShiftRows, MixColumns, AddRoundKey(round_key[round]) and increment round; 4-bit counter.
REQ-016 Round NUM_ROUNDS SHALL omit MixColumns; on its completion the FSM SHALL go to DONE.
REQ-017 Latency: accept on cycle T -> out_valid first high on cycle T+15.
REQ-018 In DONE, out_valid SHALL be 1 and ciphertext SHALL hold the final state, stable until out_valid && out_ready.
REQ-019 Output handshake SHALL return the FSM to IDLE on the next cycle; minimum accept-to-accept interval is 16 cycles.
REQ-020 out_valid SHALL be 0 in IDLE and BUSY; ciphertext MAY be arbitrary when out_valid is 0.
REQ-021 key_valid low during BUSY SHALL abort: FSM returns to IDLE next cycle, with no out_valid pulse for that block.
REQ-022 key_valid low during DONE SHALL NOT affect the held result.
REQ-023 round_key SHALL be read combinationally each BUSY cycle, not latched; the upstream must hold it stable while key_valid is high.
REQ-024 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11B.
REQ-025 in_valid while in_ready is 0 SHALL be ignored (no accept, no state change).

Reset
REQ-026 rst high SHALL force, on the next edge: FSM=IDLE, round=0, state=0, out_valid=0, in_ready=0 for that cycle.
REQ-027 rst SHALL take priority over every handshake, including mid-BUSY and DONE; any in-flight block is discarded.
REQ-028 After rst deasserts, the first accept SHALL be possible on the first cycle with key_valid && in_valid.

Structure
REQ-029 A shared package aes_pkg SHALL hold the FSM state enum, NUM_ROUNDS, AES_BLOCK_W=128, and the xtime function.
REQ-030 One sub-module aes_round SHALL compute a combinational round (in state, round key, last_round flag -> out state).
REQ-031 aes_round SHALL reuse the existing SubWord S-box (four instances for 16 bytes); the core SHALL not duplicate the S-box table.
REQ-032 Only aes_encrypt_core SHALL contain registers.

Verification
REQ-033 FIPS-197 C.3: key 000102..1e1f expanded, plaintext 00112233445566778899aabbccddeeff -> ciphertext 8ea2b7ca516745bfeafc49904b496089 with out_valid at T+15.
REQ-034 Backpressure: out_ready held 0 for 20 cycles after DONE -> ciphertext and out_valid stable throughout; in_ready stays 0; single handshake then IDLE.
REQ-035 Back-to-back: two blocks with out_ready=1 and in_valid=1 continuously -> accepts 16 cycles apart; both ciphertexts correct.
REQ-036 Reset mid-operation: rst at T+7 -> next cycle out_valid=0, FSM IDLE; a subsequent C.3 block completes correctly.
REQ-037 Key drop: key_valid=0 at T+5 -> no out_valid for that block, in_ready=0 until key_valid returns, then normal accept.
REQ-038 Gating: key_valid=0 with in_valid=1 for 10 cycles -> in_ready=0, no accept, out_valid never asserts.
